serial_sub: RTL and testbench

- Bit-serial N-bit unsigned subtractor. It is the inverse-direction companion of the team's half-adder (out/carry) block.
- Computes out = a - b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Start/busy/done handshake. Sits beside the adder blocks as the lab's sequential arithmetic unit.

---
 rtl/serial_sub.sv | 104 ++++++++++
 tb/tb_serial_sub.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: one full-subtractor cell walks a - b LSB first.
// busy/done are registered copies of the FSM state, so they trail the state by one cycle.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] out_q;
  logic             borrow_q;

  logic             a0;
  logic             b0;
  logic             diff_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;

  // Full-subtractor cell over the current operand LSBs and the running borrow.
  always_comb begin
    a0     = a_q[0];
    b0     = b_q[0];
    diff_d = a0 ^ b0 ^ br_q;
    br_d   = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    res_d  = {diff_d, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
      borrow_q <= 1'b0;
    end else begin
      busy_q <= (state_q == SHIFT);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          res_q <= res_d;
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // Result is published on the same edge that raises done.
          out_q    <= res_q;
          borrow_q <= br_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign out    = out_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_sub.sv
// Randomised and directed checks of serial_sub at WIDTH=8 and an exhaustive sweep at WIDTH=4.
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start8, busy8, done8, borrow8;
  logic [7:0] a8, b8, out8;
  logic       start4, busy4, done4, borrow4;
  logic [3:0] a4, b4, out4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .out(out8), .borrow(borrow8)
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .out(out4), .borrow(borrow4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // done and busy must never be seen together on either instance.
  always @(negedge clk) begin
    check("busy_done_overlap", {31'b0, (busy8 & done8) | (busy4 & done4)}, 32'd0);
  end

  // One complete operation on the chosen instance; called and returning at a negedge.
  task automatic run_op(input bit w4, input logic [7:0] av, input logic [7:0] bv, input string tag);
    int   w, mask, lat, nbusy, exp_out, exp_br;
    logic seen, d, bz;
    w       = w4 ? 4 : 8;
    mask    = (1 << w) - 1;
    exp_out = (int'(av & mask[7:0]) - int'(bv & mask[7:0])) & mask;
    exp_br  = ((av & mask[7:0]) < (bv & mask[7:0])) ? 1 : 0;
    if (w4) begin a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; end
    else    begin a8 = av;      b8 = bv;      start8 = 1'b1; end
    @(posedge clk);
    #1;
    start4 = 1'b0;
    start8 = 1'b0;
    // Operands moving after acceptance must not matter.
    a8 = 8'($urandom); b8 = 8'($urandom);
    a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0; nbusy = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      d  = w4 ? done4 : done8;
      bz = w4 ? busy4 : busy8;
      if (bz) nbusy++;
      if (d) seen = 1'b1;
    end
    check({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    check({tag, "_latency"}, lat, w + 1);
    check({tag, "_busy_cycles"}, nbusy, w);
    check({tag, "_out"}, w4 ? {28'b0, out4} : {24'b0, out8}, exp_out);
    check({tag, "_borrow"}, {31'b0, w4 ? borrow4 : borrow8}, exp_br);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, w4 ? done4 : done8}, 32'd0);
  endtask

  initial begin
    int   ndone, t_last, npulses;
    logic [7:0] prev_out;
    logic [7:0] dir_a [6];
    logic [7:0] dir_b [6];
    dir_a = '{8'd200, 8'd5,  8'd0, 8'hAA, 8'hFF, 8'h00};
    dir_b = '{8'd55,  8'd10, 8'd1, 8'hAA, 8'h00, 8'hFF};

    reset = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, busy8}, 32'd0);
    check("rst_done", {31'b0, done8}, 32'd0);
    check("rst_out", {24'b0, out8}, 32'd0);
    check("rst_borrow", {31'b0, borrow8}, 32'd0);
    check("rst_out4", {28'b0, out4}, 32'd0);

    // Directed pairs, including both extremes.
    for (int i = 0; i < 6; i++) run_op(1'b0, dir_a[i], dir_b[i], $sformatf("dir%0d", i));

    // Restart request during SHIFT is ignored.
    a8 = 8'd100; b8 = 8'd1; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 start8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
    @(posedge clk); #1 start8 = 1'b0; a8 = 8'hFF; b8 = 8'h00;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        check("ignore_out", {24'b0, out8}, 32'd99);
        check("ignore_borrow", {31'b0, borrow8}, 32'd0);
      end
    end
    check("ignore_single_done", ndone, 1);

    // Reset mid-operation abandons it.
    a8 = 8'd9; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy8}, 32'd0);
    check("midrst_done", {31'b0, done8}, 32'd0);
    check("midrst_out", {24'b0, out8}, 32'd0);
    check("midrst_borrow", {31'b0, borrow8}, 32'd0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_op(1'b0, 8'd9, 8'd3, "after_rst");

    // start held high: back-to-back operations.
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    prev_out = out8; t_last = -1; npulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done8) begin
        check("hold_out", {24'b0, out8}, 32'h7F);
        check("hold_borrow", {31'b0, borrow8}, 32'd0);
        if (t_last >= 0) check("hold_spacing", cyc - t_last, 10);
        t_last = cyc;
        npulses++;
        prev_out = out8;
      end else begin
        check("hold_stable", {24'b0, out8}, {24'b0, prev_out});
      end
    end
    check("hold_pulses", {31'b0, npulses >= 3}, 32'd1);
    start8 = 1'b0;
    repeat (12) @(negedge clk);

    // Random operands.
    for (int i = 0; i < 40; i++) run_op(1'b0, 8'($urandom), 8'($urandom), "rand");

    // Exhaustive at WIDTH=4.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        run_op(1'b1, 8'(ia), 8'(ib), $sformatf("w4_%0d_%0d", ia, ib));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
